// File: rtl/flash_xip_ctrl_if.sv
// Request/response bus between a read client and the flash XIP controller.
interface flash_xip_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic [23:0] req_addr;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;

   // Client side: issues read requests and consumes read data.
   modport master (
      output req_valid, req_addr, resp_ready,
      input  req_ready, resp_valid, resp_data
   );

   // Controller side.
   modport slave (
      input  req_valid, req_addr, resp_ready,
      output req_ready, resp_valid, resp_data
   );
endinterface

// File: rtl/flash_xip_ctrl.sv
// SPI flash execute-in-place read controller: one READ (0x03) command per
// request, 24-bit address, 32 data bits returned MSB-first. SPI mode 0.
module flash_xip_ctrl #(
   parameter int unsigned SCK_DIV = 2
) (
   input  logic             clock,
   input  logic             reset,
   flash_xip_ctrl_if.slave  bus,
   output logic             spi_sck,
   output logic             spi_ss,
   output logic             spi_mosi,
   input  logic             spi_miso
);

   typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

   localparam logic [7:0] DIV_LAST = 8'(SCK_DIV - 1);

   state_t      state_q, state_d;
   logic [6:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  div_cnt_q, div_cnt_d;
   logic        sck_q, sck_d;
   logic        ss_q, ss_d;
   logic        mosi_q, mosi_d;
   logic [31:0] tx_q, tx_d;
   logic [31:0] rx_q, rx_d;
   logic [31:0] frame;

   // State and datapath registers; reset returns to an idle, deselected bus.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         div_cnt_q <= '0;
         sck_q     <= 1'b0;
         ss_q      <= 1'b1;
         mosi_q    <= 1'b0;
         tx_q      <= '0;
         rx_q      <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         div_cnt_q <= div_cnt_d;
         sck_q     <= sck_d;
         ss_q      <= ss_d;
         mosi_q    <= mosi_d;
         tx_q      <= tx_d;
         rx_q      <= rx_d;
      end
   end

   // Next-state logic: SCK divider, command shift-out, data shift-in.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      div_cnt_d = div_cnt_q;
      sck_d     = sck_q;
      ss_d      = ss_q;
      mosi_d    = mosi_q;
      tx_d      = tx_q;
      rx_d      = rx_q;
      frame     = {8'h03, bus.req_addr};

      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               state_d   = XFER;
               ss_d      = 1'b0;
               sck_d     = 1'b0;
               bit_cnt_d = '0;
               div_cnt_d = '0;
               // First bit goes out with chip select; the rest queue behind
               // it and zeros fill in once the frame has shifted out.
               mosi_d    = frame[31];
               tx_d      = {frame[30:0], 1'b0};
            end
         end

         XFER: begin
            if (div_cnt_q == DIV_LAST) begin
               div_cnt_d = '0;
               sck_d     = ~sck_q;
               if (!sck_q) begin
                  // Rising edge: capture read data in the second half only.
                  if (bit_cnt_q >= 7'd32)
                     rx_d = {rx_q[30:0], spi_miso};
               end else if (bit_cnt_q == 7'd63) begin
                  state_d   = RESP;
                  ss_d      = 1'b1;
                  bit_cnt_d = '0;
                  mosi_d    = 1'b0;
               end else begin
                  // Falling edge: present the next bit for the coming low phase.
                  bit_cnt_d = bit_cnt_q + 7'd1;
                  mosi_d    = tx_q[31];
                  tx_d      = {tx_q[30:0], 1'b0};
               end
            end else begin
               div_cnt_d = div_cnt_q + 8'd1;
            end
         end

         RESP: begin
            if (bus.resp_ready)
               state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   assign bus.req_ready  = (state_q == IDLE) && !reset;
   assign bus.resp_valid = (state_q == RESP);
   assign bus.resp_data  = rx_q;
   assign spi_sck        = sck_q;
   assign spi_ss         = ss_q;
   assign spi_mosi       = mosi_q;

endmodule

// File: tb/tb_flash_xip_ctrl.sv
// Directed bench for flash_xip_ctrl: two instances (SCK_DIV=2 and 1), each
// attached to a behavioural SPI flash sampled on the falling system clock.
module tb_flash_xip_ctrl;

   logic clock;
   logic reset;
   logic sck0, ss0, mosi0, miso0;
   logic sck1, ss1, mosi1, miso1;
   int   checks;
   int   errors;

   flash_xip_ctrl_if bus0 ();
   flash_xip_ctrl_if bus1 ();

   flash_xip_ctrl #(.SCK_DIV(2)) dut0 (
      .clock(clock), .reset(reset), .bus(bus0),
      .spi_sck(sck0), .spi_ss(ss0), .spi_mosi(mosi0), .spi_miso(miso0)
   );

   flash_xip_ctrl #(.SCK_DIV(1)) dut1 (
      .clock(clock), .reset(reset), .bus(bus1),
      .spi_sck(sck1), .spi_ss(ss1), .spi_mosi(mosi1), .spi_miso(miso1)
   );

   always #5 clock = ~clock;

   // Flash contents.
   function automatic logic [31:0] mem(input logic [23:0] a);
      case (a)
         24'h000100: return 32'h12345678;
         24'h000000: return 32'hCAFEF00D;
         24'hFFFFFC: return 32'hDEADBEEF;
         default:    return {a[7:0], a} ^ 32'h5A5A5A5A;
      endcase
   endfunction

   // Flash model state, one slot per instance.
   logic        prev_sck [2];
   logic        prev_ss  [2];
   logic        cur_sck  [2];
   logic        cur_ss   [2];
   logic        cur_mosi [2];
   logic        m_miso   [2];
   logic        mosi_hi  [2];
   logic [31:0] cmd      [2];
   logic [31:0] word     [2];
   int          rises    [2];
   int          hi_cyc   [2];

   // Mode-0 flash: command captured on SCK rise, data driven after SCK fall.
   always @(negedge clock) begin
      cur_sck[0] = sck0;  cur_ss[0] = ss0;  cur_mosi[0] = mosi0;
      cur_sck[1] = sck1;  cur_ss[1] = ss1;  cur_mosi[1] = mosi1;
      for (int i = 0; i < 2; i++) begin
         if (cur_ss[i]) begin
            m_miso[i] = 1'b0;
         end else begin
            if (prev_ss[i]) begin
               rises[i] = 0; hi_cyc[i] = 0; cmd[i] = '0; mosi_hi[i] = 1'b0;
            end
            if (cur_sck[i]) hi_cyc[i]++;
            if (cur_sck[i] && !prev_sck[i]) begin
               if (rises[i] < 32) cmd[i] = {cmd[i][30:0], cur_mosi[i]};
               else               mosi_hi[i] = mosi_hi[i] | cur_mosi[i];
               rises[i]++;
               if (rises[i] == 32) word[i] = mem(cmd[i][23:0]);
            end
            if (!cur_sck[i] && prev_sck[i] && rises[i] >= 32 && rises[i] < 64)
               m_miso[i] = word[i][63 - rises[i]];
         end
         prev_sck[i] = cur_sck[i];
         prev_ss[i]  = cur_ss[i];
      end
      miso0 = m_miso[0];
      miso1 = m_miso[1];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic f_rdy(input int i);
      return (i == 0) ? bus0.req_ready : bus1.req_ready;
   endfunction
   function automatic logic f_rv(input int i);
      return (i == 0) ? bus0.resp_valid : bus1.resp_valid;
   endfunction
   function automatic logic [31:0] f_data(input int i);
      return (i == 0) ? bus0.resp_data : bus1.resp_data;
   endfunction
   function automatic logic f_ss(input int i);
      return (i == 0) ? ss0 : ss1;
   endfunction
   function automatic logic f_sck(input int i);
      return (i == 0) ? sck0 : sck1;
   endfunction

   task automatic set_req(input int i, input logic v, input logic [23:0] a);
      if (i == 0) begin bus0.req_valid = v; bus0.req_addr = a; end
      else        begin bus1.req_valid = v; bus1.req_addr = a; end
   endtask
   task automatic set_addr(input int i, input logic [23:0] a);
      if (i == 0) bus0.req_addr = a; else bus1.req_addr = a;
   endtask
   task automatic set_rr(input int i, input logic v);
      if (i == 0) bus0.resp_ready = v; else bus1.resp_ready = v;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Present a request and step past the accepting edge (returns in cycle T+1).
   task automatic accept(input int i, input logic [23:0] a);
      int n;
      set_req(i, 1'b1, a);
      n = 0;
      while (!f_rdy(i) && n < 20) begin step(); n++; end
      check("accept_ready", {31'd0, f_rdy(i)}, 32'd1);
      step();
   endtask

   // Called in cycle T+1; waits for resp_valid and checks the whole transfer.
   task automatic wait_resp(input int i, input int div, input logic [23:0] a, input bit toggle);
      int n;
      check("ss_low_t1", {31'd0, f_ss(i)}, 32'd0);
      check("sck_low_t1", {31'd0, f_sck(i)}, 32'd0);
      n = 1;
      while (!f_rv(i) && n < 2000) begin
         if (toggle) set_addr(i, 24'($urandom()));
         step();
         n++;
      end
      check("latency", 32'(n), 32'(1 + 128 * div));
      check("ss_high_resp", {31'd0, f_ss(i)}, 32'd1);
      check("sck_low_resp", {31'd0, f_sck(i)}, 32'd0);
      check("resp_data", f_data(i), mem(a));
      check("mosi_frame", cmd[i], {8'h03, a});
      check("mosi_tail_zero", {31'd0, mosi_hi[i]}, 32'd0);
      check("sck_rises", 32'(rises[i]), 32'd64);
      check("sck_high_cycles", 32'(hi_cyc[i]), 32'(64 * div));
   endtask

   // Complete the response handshake and confirm return to IDLE.
   task automatic finish_resp(input int i);
      set_rr(i, 1'b1);
      step();
      check("rv_after_hs", {31'd0, f_rv(i)}, 32'd0);
      check("idle_after_hs", {31'd0, f_rdy(i)}, 32'd1);
      set_rr(i, 1'b0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      clock  = 1'b0;
      reset  = 1'b1;
      for (int i = 0; i < 2; i++) begin
         prev_sck[i] = 1'b0; prev_ss[i] = 1'b1; m_miso[i] = 1'b0;
         mosi_hi[i] = 1'b0; cmd[i] = '0; word[i] = '0; rises[i] = 0; hi_cyc[i] = 0;
      end
      miso0 = 1'b0; miso1 = 1'b0;
      set_req(0, 1'b0, '0); set_req(1, 1'b0, '0);
      set_rr(0, 1'b0);      set_rr(1, 1'b0);

      // Reset values and req_ready held low during reset.
      step();
      check("rst_req_ready", {31'd0, bus0.req_ready}, 32'd0);
      check("rst_ss", {31'd0, ss0}, 32'd1);
      check("rst_sck", {31'd0, sck0}, 32'd0);
      check("rst_mosi", {31'd0, mosi0}, 32'd0);
      check("rst_resp_valid", {31'd0, bus0.resp_valid}, 32'd0);
      check("rst_resp_data", bus0.resp_data, 32'd0);
      step(); step();
      reset = 1'b0;
      #1;
      check("ready_after_rst", {31'd0, bus0.req_ready}, 32'd1);
      check("ready_after_rst1", {31'd0, bus1.req_ready}, 32'd1);

      // Basic read at SCK_DIV=2, then hold resp_ready low for 10 cycles.
      accept(0, 24'h000100);
      set_req(0, 1'b0, 24'h000100);
      wait_resp(0, 2, 24'h000100, 1'b0);
      for (int k = 0; k < 10; k++) begin
         step();
         check("hold_rv", {31'd0, bus0.resp_valid}, 32'd1);
         check("hold_data", bus0.resp_data, 32'h12345678);
         check("hold_ready", {31'd0, bus0.req_ready}, 32'd0);
         check("hold_ss", {31'd0, ss0}, 32'd1);
      end
      finish_resp(0);

      // Same read at SCK_DIV=1.
      accept(1, 24'h000100);
      set_req(1, 1'b0, 24'h000100);
      wait_resp(1, 1, 24'h000100, 1'b0);
      finish_resp(1);

      // Back-to-back with req_valid held high; second address queued during XFER.
      accept(0, 24'h000000);
      set_addr(0, 24'hFFFFFC);
      wait_resp(0, 2, 24'h000000, 1'b0);
      set_rr(0, 1'b1);
      step();
      check("b2b_idle_rv", {31'd0, bus0.resp_valid}, 32'd0);
      check("b2b_idle_ready", {31'd0, bus0.req_ready}, 32'd1);
      check("b2b_gap_ss", {31'd0, ss0}, 32'd1);
      set_rr(0, 1'b0);
      step();
      set_req(0, 1'b0, 24'hFFFFFC);
      wait_resp(0, 2, 24'hFFFFFC, 1'b0);
      finish_resp(0);

      // Address toggled during XFER must not disturb the latched one.
      accept(0, 24'hABCDEF);
      set_req(0, 1'b0, 24'hABCDEF);
      wait_resp(0, 2, 24'hABCDEF, 1'b1);
      finish_resp(0);

      // Reset during SCK period 40 (cycles T+157..T+160 at SCK_DIV=2).
      accept(0, 24'h000100);
      set_req(0, 1'b0, 24'h000100);
      for (int k = 1; k < 158; k++) step();
      check("pre_rst_ss", {31'd0, ss0}, 32'd0);
      reset = 1'b1;
      step();
      check("abort_ss", {31'd0, ss0}, 32'd1);
      check("abort_sck", {31'd0, sck0}, 32'd0);
      check("abort_rv", {31'd0, bus0.resp_valid}, 32'd0);
      check("abort_data", bus0.resp_data, 32'd0);
      reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         check("abort_no_rv", {31'd0, bus0.resp_valid}, 32'd0);
      end
      accept(0, 24'h000000);
      set_req(0, 1'b0, 24'h000000);
      wait_resp(0, 2, 24'h000000, 1'b0);
      finish_resp(0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
